// File: rtl/golden_nonce_uart_tx_if.sv
// Golden-nonce event bus from the miner core: a single-cycle valid pulse
// qualifying a 32-bit corrected nonce. There is no ready signal because the
// miner core cannot be stalled.
interface golden_nonce_uart_tx_if;
    logic        golden_valid;
    logic [31:0] golden_nonce;

    modport master (output golden_valid, output golden_nonce);
    modport slave  (input  golden_valid, input  golden_nonce);
endinterface

// File: rtl/golden_nonce_uart_tx.sv
// Golden-nonce reporter. Queues nonces from the miner core in a small FIFO and
// sends each one as a framed byte stream, LSB byte first, on an 8N1 UART line.
// When the FIFO is full and nothing leaves it that cycle, the incoming nonce is
// dropped, counted in drop_count (saturating) and flagged on the sticky overflow.
// Optional build macro GOLDEN_NONCE_HEADER_EN prefixes every frame with the
// sync byte 0xA5, making frames five bytes long instead of four.
module golden_nonce_uart_tx #(
    parameter int DEPTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                     hash_clk,
    input  logic                     rst_n,
    golden_nonce_uart_tx_if.slave    nonce_if,
    input  logic                     clr_overflow,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic [7:0]               drop_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef GOLDEN_NONCE_HEADER_EN
    localparam logic [2:0] LAST_BYTE = 3'd4;
`else
    localparam logic [2:0] LAST_BYTE = 3'd3;
`endif

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q;
    logic [CW-1:0]   baud_q;
    logic [2:0]      bit_idx_q;
    logic [2:0]      byte_idx_q;
    logic [31:0]     word_q;
    logic            tx_q;

    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            busy_q;
    logic            overflow_q;
    logic [7:0]      drop_q;

    logic            empty;
    logic            full;
    logic            baud_done;
    logic            frame_end;
    logic            pop;
    logic            push;
    logic            drop;
    logic            going_idle;
    logic [1:0]      byte_sel;
    logic [7:0]      cur_byte;

    assign empty      = (level_q == '0);
    assign full       = (level_q == LW'(DEPTH));
    assign baud_done  = (baud_q == CW'(CLKS_PER_BIT - 1));
    assign frame_end  = (state_q == STOP) && baud_done && (byte_idx_q == LAST_BYTE);
    // The head leaves the FIFO either from IDLE or straight out of the last
    // stop bit, so consecutive frames run with no idle gap.
    assign pop        = !empty && ((state_q == IDLE) || frame_end);
    // A full FIFO still accepts a nonce when the head is popped that same cycle.
    assign push       = nonce_if.golden_valid && (!full || pop);
    assign drop       = nonce_if.golden_valid && full && !pop;
    assign going_idle = empty && ((state_q == IDLE) || frame_end);

    // Next occupancy from the push/pop pair of this cycle.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    // Select the byte currently on the wire from the captured nonce.
    always_comb begin
`ifdef GOLDEN_NONCE_HEADER_EN
        byte_sel = 2'(byte_idx_q - 3'd1);
        cur_byte = (byte_idx_q == 3'd0) ? 8'hA5 : 8'(word_q >> {byte_sel, 3'b000});
`else
        byte_sel = byte_idx_q[1:0];
        cur_byte = 8'(word_q >> {byte_sel, 3'b000});
`endif
    end

    // FIFO storage write port.
    // NOTE: the storage array is not reset; the pointers and level define which entries are valid.
    always_ff @(posedge hash_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= nonce_if.golden_nonce;
        end
    end

    // FIFO pointers, occupancy and the registered busy flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_d;
            busy_q  <= !going_idle || (level_d != '0);
        end
    end

    // Drop accounting; a drop in the same cycle as a clear wins.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (clr_overflow)         drop_q <= 8'd1;
            else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
        end else if (clr_overflow) begin
            overflow_q <= 1'b0;
            drop_q     <= 8'd0;
        end
    end

    // UART framing FSM; tx is registered from the current state, so it trails the state by one cycle.
    always_ff @(posedge hash_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            tx_q       <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q   <= 1'b1;
                    baud_q <= '0;
                    if (pop) begin
                        word_q     <= mem[rd_ptr_q];
                        byte_idx_q <= '0;
                        state_q    <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                DATA: begin
                    tx_q <= cur_byte[bit_idx_q];
                    if (baud_done) begin
                        baud_q <= '0;
                        if (bit_idx_q == 3'd7) state_q   <= STOP;
                        else                   bit_idx_q <= bit_idx_q + 3'd1;
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (baud_done) begin
                        baud_q <= '0;
                        if (byte_idx_q != LAST_BYTE) begin
                            byte_idx_q <= byte_idx_q + 3'd1;
                            state_q    <= START;
                        end else if (pop) begin
                            word_q     <= mem[rd_ptr_q];
                            byte_idx_q <= '0;
                            state_q    <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_level = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_golden_nonce_uart_tx.sv
// Self-checking bench for golden_nonce_uart_tx (DEPTH=4, CLKS_PER_BIT=4).
// A frame-timeline model (queue of nonces plus "edges since pop" into a flat
// bit vector of the frame) predicts tx/busy/fifo_level/overflow/drop_count on
// every cycle; directed scenarios pin exact timing and decoded bytes.
module tb_golden_nonce_uart_tx;

    localparam int DEPTH = 4;
    localparam int C     = 4;
`ifdef GOLDEN_NONCE_HEADER_EN
    localparam int NBYTES = 5;
`else
    localparam int NBYTES = 4;
`endif
    localparam int FRAME = NBYTES * 10 * C;
    localparam int LOGN  = 16384;

    typedef logic [7:0] bytes_t [5];

    logic                    hash_clk;
    logic                    rst_n = 1'b0;
    logic                    clr_overflow = 1'b0;
    logic                    tx;
    logic                    busy;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic                    overflow;
    logic [7:0]              drop_count;

    golden_nonce_uart_tx_if nif ();

    golden_nonce_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(C)) dut (
        .hash_clk     (hash_clk),
        .rst_n        (rst_n),
        .nonce_if     (nif),
        .clr_overflow (clr_overflow),
        .tx           (tx),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    initial begin
        hash_clk = 1'b0;
        forever #5 hash_clk = ~hash_clk;
    end

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   peak  = 0;
    logic tx_log   [LOGN];
    logic busy_log [LOGN];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_q[$];
    bit          m_active = 0;
    int          m_k      = 0;
    logic        m_bits [50];
    logic        m_tx     = 1'b1;
    logic        m_busy   = 1'b0;
    int          m_level  = 0;
    logic        m_ovf    = 1'b0;
    int          m_drops  = 0;

    function automatic bytes_t build_exp(input logic [31:0] n);
        bytes_t r;
        for (int k = 0; k < 5; k++) r[k] = 8'h00;
`ifdef GOLDEN_NONCE_HEADER_EN
        r[0] = 8'hA5;
        for (int k = 0; k < 4; k++) r[k+1] = n[8*k +: 8];
`else
        for (int k = 0; k < 4; k++) r[k] = n[8*k +: 8];
`endif
        return r;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_k = 0; m_tx = 1'b1; m_busy = 1'b0;
        m_level = 0; m_ovf = 1'b0; m_drops = 0;
    endtask

    task automatic model_step();
        bytes_t b;
        bit full, pop;
        full = (m_q.size() == DEPTH);
        pop  = 0;
        if (m_active) begin
            m_k++;
            if (m_k == FRAME) m_active = 0;
        end
        if (!m_active && m_q.size() != 0) pop = 1;
        if (pop) begin
            b = build_exp(m_q.pop_front());
            for (int k = 0; k < NBYTES; k++) begin
                m_bits[k*10] = 1'b0;
                for (int j = 0; j < 8; j++) m_bits[k*10+1+j] = b[k][j];
                m_bits[k*10+9] = 1'b1;
            end
            m_active = 1;
            m_k = 0;
        end
        if (nif.golden_valid && (!full || pop)) begin
            m_q.push_back(nif.golden_nonce);
        end else if (nif.golden_valid) begin
            m_ovf = 1'b1;
            m_drops = clr_overflow ? 1 : ((m_drops == 255) ? 255 : m_drops + 1);
        end else if (clr_overflow) begin
            m_ovf = 1'b0;
            m_drops = 0;
        end
        m_tx    = (m_active && m_k >= 1) ? m_bits[(m_k-1)/C] : 1'b1;
        m_level = m_q.size();
        m_busy  = m_active || (m_q.size() != 0);
    endtask

    // Model advances on every clock edge and on asynchronous reset.
    initial forever begin
        @(posedge hash_clk or negedge rst_n);
        if (hash_clk) cyc++;
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare process: every negedge, log the line and check all outputs.
    initial forever begin
        @(negedge hash_clk);
        if (cyc < LOGN) begin
            tx_log[cyc]   = tx;
            busy_log[cyc] = busy;
        end
        if (int'(fifo_level) > peak) peak = int'(fifo_level);
        check("tx", tx, m_tx);
        check("busy", busy, m_busy);
        check("fifo_level", fifo_level, m_level);
        check("overflow", overflow, m_ovf);
        check("drop_count", drop_count, m_drops);
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic v, input logic [31:0] n, input logic clr, output int edge_no);
        @(negedge hash_clk);
        nif.golden_valid = v;
        nif.golden_nonce = n;
        clr_overflow     = clr;
        edge_no          = cyc + 1;
    endtask

    task automatic idle(input int n);
        int e;
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, e);
    endtask

    // Make the next drive() land on clock edge 'target'.
    task automatic wait_edge(input int target);
        int e;
        for (int i = 0; i < 50000 && cyc < target - 2; i++) drive(1'b0, 32'h0, 1'b0, e);
        check("wait_edge_alignment", cyc, target - 2);
    endtask

    task automatic decode_frame(input int s, input bytes_t exp, input string tag);
        logic [7:0] b;
        logic       v;
        bit         ok;
        int         base;
        for (int k = 0; k < NBYTES; k++) begin
            base = s + k * 10 * C;
            ok = 1;
            b = 8'h00;
            for (int c = 0; c < 10; c++) begin
                v = tx_log[base + c*C];
                for (int j = 1; j < C; j++) if (tx_log[base + c*C + j] !== v) ok = 0;
                if (c == 0 && v !== 1'b0) ok = 0;
                if (c == 9 && v !== 1'b1) ok = 0;
                if (c >= 1 && c <= 8) b[c-1] = v;
            end
            check($sformatf("%s_framing%0d", tag, k), {31'd0, ok}, 32'd1);
            check($sformatf("%s_byte%0d", tag, k), b, exp[k]);
        end
    endtask

    // ---------------- scenarios ----------------
    initial begin
        bytes_t      lit;
        int          e, e0, s, tr;
        logic [31:0] rn [7];

        nif.golden_valid = 1'b0;
        nif.golden_nonce = 32'h0;

        // Reset and idle.
        repeat (3) @(negedge hash_clk);
        rst_n = 1'b1;
        idle(50);
        check("idle_tx", tx, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_level", fifo_level, 0);

        // Single nonce with literal byte and timing expectations.
`ifdef GOLDEN_NONCE_HEADER_EN
        lit = '{8'hA5, 8'h78, 8'h56, 8'h34, 8'h12};
`else
        lit = '{8'h78, 8'h56, 8'h34, 8'h12, 8'h00};
`endif
        drive(1'b1, 32'h12345678, 1'b0, e);
        idle(FRAME + 8);
        check("single_no_early_start", tx_log[e+1], 1'b1);
        check("single_start_at_2", tx_log[e+2], 1'b0);
        decode_frame(e + 2, lit, "single");
        check("single_busy_last", busy_log[e+FRAME], 1'b1);
        check("single_busy_drop", busy_log[e+FRAME+1], 1'b0);
        check("single_line_idle_after", tx_log[e+FRAME+2], 1'b1);

        // Back-to-back 1..5: contiguous frames, peak level 4, no overflow.
        peak = 0;
        drive(1'b1, 32'd1, 1'b0, e0);
        for (int i = 2; i <= 5; i++) drive(1'b1, 32'(i), 1'b0, e);
        idle(5 * FRAME + 8);
        for (int i = 0; i < 5; i++)
            decode_frame(e0 + 2 + i * FRAME, build_exp(32'(i + 1)), $sformatf("b2b%0d", i + 1));
        check("b2b_peak_level", peak, 4);
        check("b2b_overflow", overflow, 1'b0);

        // Overflow: 7 random nonces, last two dropped, then clear.
        for (int i = 0; i < 7; i++) rn[i] = $urandom;
        drive(1'b1, rn[0], 1'b0, e0);
        for (int i = 1; i < 7; i++) drive(1'b1, rn[i], 1'b0, e);
        idle(1);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_drops", drop_count, 2);
        drive(1'b0, 32'h0, 1'b1, e);
        idle(1);
        check("ovf_clr_flag", overflow, 1'b0);
        check("ovf_clr_drops", drop_count, 0);
        idle(5 * FRAME + 8);
        for (int i = 0; i < 5; i++)
            decode_frame(e0 + 2 + i * FRAME, build_exp(rn[i]), $sformatf("ovf%0d", i + 1));

        // Full FIFO with a push exactly on the pop edge.
        for (int i = 0; i < 6; i++) rn[i] = $urandom;
        drive(1'b1, rn[0], 1'b0, e0);
        for (int i = 1; i < 5; i++) drive(1'b1, rn[i], 1'b0, e);
        wait_edge(e0 + 1 + FRAME);
        drive(1'b1, rn[5], 1'b0, e);
        idle(1);
        check("fullpop_level", fifo_level, 4);
        check("fullpop_no_drop", drop_count, 0);
        check("fullpop_no_ovf", overflow, 1'b0);
        idle(5 * FRAME + 8);
        for (int i = 0; i < 6; i++)
            decode_frame(e0 + 2 + i * FRAME, build_exp(rn[i]), $sformatf("fullpop%0d", i + 1));

        // Reset during the data bits of byte 2, then a fresh nonce.
        drive(1'b1, 32'h11223344, 1'b0, e0);
        drive(1'b1, 32'h55667788, 1'b0, e);
        drive(1'b1, 32'h99AABBCC, 1'b0, e);
        tr = e0 + 2 + 2 * 10 * C + C + 2;
        for (int i = 0; i < 50000 && cyc < tr; i++) drive(1'b0, 32'h0, 1'b0, e);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_level", fifo_level, 0);
        check("midrst_busy", busy, 1'b0);
        repeat (3) @(negedge hash_clk);
        rst_n = 1'b1;
        idle(2);
`ifdef GOLDEN_NONCE_HEADER_EN
        lit = '{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`else
        lit = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
`endif
        drive(1'b1, 32'hDEADBEEF, 1'b0, e);
        idle(FRAME + 8);
        decode_frame(e + 2, lit, "post_rst");

        // Random soak with sparse pulses, clears and one long burst.
        for (int i = 0; i < 2000; i++) begin
            if (i == 700) begin
                for (int j = 0; j < 8; j++) drive(1'b1, $urandom, 1'b0, e);
            end
            drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0, $urandom,
                  ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, e);
        end
        idle((DEPTH + 2) * FRAME);
        check("soak_drained_busy", busy, 1'b0);
        check("soak_drained_tx", tx, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
